// File: rtl/mac_pkg.sv
// mac_pkg: shared types and constants for the MAC lane array.
//   phase_e  - sequencer phase tracked by the lane array
//   ERR_SEQ  - err bit index for sequence errors
//   ERR_OVR  - err bit index for result overrun
//   acc_w()  - accumulator width that cannot overflow for SIZE full-scale products
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MULT = 2'd2,
    ACC  = 2'd3
  } phase_e;

  localparam int ERR_SEQ = 0;
  localparam int ERR_OVR = 1;

  function automatic int acc_w(input int size, input int data_w);
    return 2 * data_w + $clog2(size) + 1;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// mac_lane: one multiply-accumulate lane.
//   clk, reset  - clock and synchronous active-high reset
//   ld          - capture operands; armed flag takes sel
//   mu          - prod <= a_reg * b_reg (armed lanes only)
//   ac          - acc <= acc + sext(prod) (armed lanes only, wraps)
//   clr         - end of job: clear acc and armed flag (overrides ld/mu/ac)
//   sel         - lane participates in this iteration
//   a, b        - signed operands
//   acc         - accumulator value
module mac_lane
  import mac_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 21
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld,
  input  logic              mu,
  input  logic              ac,
  input  logic              clr,
  input  logic              sel,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic [DATA_W-1:0]          a_q, a_d;
  logic [DATA_W-1:0]          b_q, b_d;
  logic [2*DATA_W-1:0]        prod_q, prod_d;
  logic [ACC_W-1:0]           acc_q, acc_d;
  logic                       armed_q, armed_d;
  logic signed [2*DATA_W-1:0] a_ext, b_ext;
  logic [ACC_W-1:0]           prod_ext;

  // Sign-extend operands to product width so the low 2*DATA_W bits of the
  // multiply are the exact signed product.
  assign a_ext    = {{DATA_W{a_q[DATA_W-1]}}, a_q};
  assign b_ext    = {{DATA_W{b_q[DATA_W-1]}}, b_q};
  assign prod_ext = {{(ACC_W-2*DATA_W){prod_q[2*DATA_W-1]}}, prod_q};

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    acc_d   = acc_q;
    armed_d = armed_q;
    if (clr) begin
      acc_d   = '0;
      armed_d = 1'b0;
    end else if (ld) begin
      armed_d = sel;
      if (sel) begin
        a_d = a;
        b_d = b;
      end
    end else if (mu) begin
      if (armed_q) prod_d = a_ext * b_ext;
    end else if (ac) begin
      if (armed_q) acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      acc_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      armed_q <= armed_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mac_lane_array.sv
// mac_lane_array: SIZE-lane MAC datapath driven by the MAC sequencer.
//   clk, reset          - clock, synchronous active-high reset
//   load_en/mult_en/acc_en - sequencer strobes (one per cycle expected)
//   memsel              - per-lane activation, sampled on accepted load_en
//   done                - 1-cycle end-of-job pulse; publishes all accumulators
//   a_data, b_data      - packed signed operands, lane i at [i*DATA_W +: DATA_W]
//   res_data            - packed results, lane i at [i*ACC_W +: ACC_W]
//   res_valid/res_ready - result handshake toward writeback
//   busy                - job in progress (first accepted load until done)
//   err                 - sticky {overrun, sequence error}
module mac_lane_array
  import mac_pkg::*;
#(
  parameter int SIZE   = 16,
  parameter int DATA_W = 8,
  parameter int ACC_W  = acc_w(SIZE, DATA_W)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_en,
  input  logic                   mult_en,
  input  logic                   acc_en,
  input  logic [SIZE-1:0]        memsel,
  input  logic                   done,
  input  logic [SIZE*DATA_W-1:0] a_data,
  input  logic [SIZE*DATA_W-1:0] b_data,
  output logic [SIZE*ACC_W-1:0]  res_data,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   busy,
  output logic [1:0]             err
);

  phase_e                phase_q, phase_d;
  logic                  multi_en, ld_ok, mu_ok, ac_ok, seq_err;
  logic                  publish, overrun;
  logic [SIZE*ACC_W-1:0] acc_vec;
  logic [SIZE*ACC_W-1:0] res_data_q, res_data_d;
  logic                  res_valid_q, res_valid_d;
  logic                  busy_q, busy_d;
  logic [1:0]            err_q, err_d;

  // Phase FSM and sequence checker. acc_en outside ACC is silently ignored
  // because the sequencer holds it high after the last accumulate.
  always_comb begin
    phase_d  = phase_q;
    ld_ok    = 1'b0;
    mu_ok    = 1'b0;
    ac_ok    = 1'b0;
    seq_err  = 1'b0;
    multi_en = (load_en & mult_en) | (load_en & acc_en) | (mult_en & acc_en);
    if (multi_en) begin
      seq_err = 1'b1;
    end else begin
      case (phase_q)
        IDLE, LOAD: begin
          if (load_en) begin
            ld_ok   = 1'b1;
            phase_d = MULT;
          end
          if (mult_en) seq_err = 1'b1;
        end
        MULT: begin
          if (mult_en) begin
            mu_ok   = 1'b1;
            phase_d = ACC;
          end
          if (load_en) seq_err = 1'b1;
        end
        ACC: begin
          if (acc_en) begin
            ac_ok   = 1'b1;
            phase_d = LOAD;
          end
          if (load_en || mult_en) seq_err = 1'b1;
        end
        default: phase_d = IDLE;
      endcase
    end
    // done ends the job regardless of any strobe in the same cycle; ending
    // mid-triple is still published but flagged.
    if (done) begin
      phase_d = IDLE;
      ld_ok   = 1'b0;
      mu_ok   = 1'b0;
      ac_ok   = 1'b0;
      if (phase_q == MULT || phase_q == ACC) seq_err = 1'b1;
    end
  end

  // Result register: a held, unaccepted result is never overwritten.
  always_comb begin
    publish     = done & (~res_valid_q | res_ready);
    overrun     = done & res_valid_q & ~res_ready;
    res_data_d  = publish ? acc_vec : res_data_q;
    res_valid_d = (res_valid_q & ~res_ready) | publish;
    busy_d      = busy_q;
    if (ld_ok) busy_d = 1'b1;
    if (done)  busy_d = 1'b0;
    err_d = err_q;
    if (seq_err) err_d[ERR_SEQ] = 1'b1;
    if (overrun) err_d[ERR_OVR] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q     <= IDLE;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= '0;
    end else begin
      phase_q     <= phase_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
    mac_lane #(
      .DATA_W(DATA_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .ld   (ld_ok),
      .mu   (mu_ok),
      .ac   (ac_ok),
      .clr  (done),
      .sel  (memsel[gi]),
      .a    (a_data[gi*DATA_W +: DATA_W]),
      .b    (b_data[gi*DATA_W +: DATA_W]),
      .acc  (acc_vec[gi*ACC_W +: ACC_W])
    );
  end

  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
